// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing for the cache line <-> 64-bit burst memory adaptor.
package cacheline_adaptor_pkg;

   localparam int unsigned S_LINE        = 256;
   localparam int unsigned S_BURST       = 64;
   localparam int unsigned ADAPTOR_BEATS = S_LINE / S_BURST;
   localparam int unsigned CNT_W         = $clog2(ADAPTOR_BEATS);
   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned OFFS_W        = $clog2(S_LINE / 8);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } adaptor_state_t;

   // Line-aligned burst start address: byte offset within the line cleared.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits one 256-bit cache line read/write into a 4-beat 64-bit memory burst,
// answering the cache with a single-cycle resp_o once the burst completes.
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   address_i,
   input  logic [S_LINE-1:0]   line_i,
   output logic [S_LINE-1:0]   line_o,
   input  logic                read_i,
   input  logic                write_i,
   output logic                resp_o,
   output logic [ADDR_W-1:0]   address_o,
   input  logic [S_BURST-1:0]  burst_i,
   output logic [S_BURST-1:0]  burst_o,
   output logic                read_o,
   output logic                write_o,
   input  logic                resp_i
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ADAPTOR_BEATS - 1);

   adaptor_state_t    state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [S_LINE-1:0] wbuf;

   assign cnt_nxt = cnt + CNT_W'(1);

   // Single registered FSM; every output is a flop updated alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         wbuf      <= '0;
         line_o    <= '0;
         burst_o   <= '0;
         address_o <= '0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         resp_o    <= 1'b0;
      end else begin
         resp_o <= 1'b0;
         unique case (state)
            IDLE: begin
               // Write wins a tie; a still-held read is picked up after DONE.
               if (write_i) begin
                  state     <= WRITE;
                  cnt       <= '0;
                  wbuf      <= line_i;
                  burst_o   <= line_i[S_BURST-1:0];
                  address_o <= line_addr(address_i);
                  write_o   <= 1'b1;
               end else if (read_i) begin
                  state     <= READ;
                  cnt       <= '0;
                  address_o <= line_addr(address_i);
                  read_o    <= 1'b1;
               end
            end
            READ: begin
               if (resp_i) begin
                  line_o[S_BURST*cnt +: S_BURST] <= burst_i;
                  if (cnt == LAST_BEAT) begin
                     state  <= DONE;
                     cnt    <= '0;
                     read_o <= 1'b0;
                     resp_o <= 1'b1;
                  end else begin
                     cnt <= cnt_nxt;
                  end
               end
            end
            WRITE: begin
               if (resp_i) begin
                  if (cnt == LAST_BEAT) begin
                     state   <= DONE;
                     cnt     <= '0;
                     burst_o <= '0;
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                  end else begin
                     cnt     <= cnt_nxt;
                     burst_o <= wbuf[S_BURST*cnt_nxt +: S_BURST];
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               address_o <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits between the cache datapath/controller's physical-memory port and the 64-bit burst memory.
- Converts one 256-bit line read or write into a 4-beat 64-bit burst.
- Acts as the memory-side responder to the cache's pmem_read/pmem_write/pmem_resp handshake, and as the initiator toward burst memory.

Parameters:
- s_line, 256, cache line width in bits.
- s_burst, 64, memory beat width in bits.
- num_beats, s_line/s_burst (4), beats per line; localparam, not overridable.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- address_i  input  32  line address from cache (pmem_address)
- line_i  input  256  line to write back (pmem_wdata)
- line_o  output  256  assembled line returned (pmem_rdata)
- read_i  input  1  cache line read request, level, held until resp_o
- write_i  input  1  cache line write request, level, held until resp_o
- resp_o  output  1  one-cycle completion pulse to cache
- address_o  output  32  burst start address to memory
- burst_i  input  64  read beat from memory
- burst_o  output  64  write beat to memory
- read_o  output  1  memory read request
- write_o  output  1  memory write request
- resp_i  input  1  memory beat strobe: a read beat is valid / a write beat is accepted

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high (clk, rst).
- In the reset cycle and afterwards, all of the following are 0:
  - state=IDLE, beat counter=0, line buffer=0, address register=0.
  - line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
- Reset mid-burst aborts the transaction immediately. No resp_o is produced; memory must tolerate the dropped request.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1 → latch address_i and line_i; cnt=0; go WRITE.
  - Else read_i=1 → latch address_i; cnt=0; go READ.
  - write_i and read_i both high → write wins; read is serviced after the write's resp_o if still held.
  - resp_i in IDLE is ignored.
- Address: address_o = {latched address[31:5], 5'b0}. It is held constant for the whole transaction and is 0 in IDLE.
- READ:
  - read_o=1 every cycle in READ.
  - Each cycle with resp_i=1: line_buf[64*cnt +: 64] <= burst_i; cnt <= cnt+1.
  - resp_i=0 cycles (gaps) hold cnt and data.
  - On the beat with cnt==3 and resp_i=1 → go DONE.
- WRITE:
  - write_o=1 and burst_o = wbuf[64*cnt +: 64] every cycle in WRITE.
  - Each resp_i=1 cycle advances cnt; gaps hold cnt.
  - cnt==3 with resp_i=1 → go DONE.
- DONE:
  - resp_o=1 for exactly this one cycle; read_o=write_o=0. Then go IDLE unconditionally.
  - read_i/write_i still high in the DONE cycle are ignored.
  - The cache drops requests on seeing resp_o. A request still high in the following IDLE cycle starts a new transaction.
- line_o = line_buf. It is valid in the DONE cycle of a read and holds until the next read's first beat overwrites the low 64 bits.
- Beats are ordered low to high: beat 0 = bits [63:0].
- Latency: minimum read or write = 1 (accept) + 4 beats + 1 DONE. resp_o rises 5 cycles after the request is first sampled high in IDLE, with no gaps.
- cnt is 2 bits. Wrap from 3 to 0 occurs only on the transition to DONE.
- Requests arriving while busy are not queued; they are level-held by the cache.

Decomposition:
- pkg_cache gains:
  - adaptor_state_t enum {IDLE, READ, WRITE, DONE}.
  - localparam ADAPTOR_BEATS=4.
- Single module; no sub-module needed. Line buffer and beat counter stay inline (≈150 lines).

Test Plan:
- Read, no gaps:
  - Stimulus: address_i=32'h0000_1234, read_i=1; memory returns resp_i=1 for 4 cycles with burst_i=64'hA0,A1,A2,A3 (beat index in low byte).
  - Required: address_o=32'h0000_1220; read_o high 4 cycles; resp_o one pulse 5 cycles after the request; line_o={A3,A2,A1,A0}.
- Write, with gaps:
  - Stimulus: line_i={64'h4,64'h3,64'h2,64'h1}, write_i=1; memory asserts resp_i on cycles 1,3,4,7.
  - Required: burst_o=1 until the first accept, then 2, 3, 4 in order; write_o high throughout; resp_o once after the fourth accept.
- Simultaneous request:
  - Stimulus: read_i=write_i=1 in IDLE.
  - Required: WRITE entered, write_o=1, read_o=0; after resp_o, a held read_i starts a READ.
- Reset mid-read:
  - Stimulus: rst=1 after 2 read beats.
  - Required: next cycle all outputs 0, state IDLE; a new read yields a clean line with no stale beats.
- Back-to-back:
  - Stimulus: write then read to 32'hFFFF_FFE0 with requests held until resp_o.
  - Required: two distinct resp_o pulses; address_o=32'hFFFF_FFE0 for both; no beat miscount.
- Spurious strobe:
  - Stimulus: resp_i=1 in IDLE.
  - Required: no state change, no resp_o.
